mem_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-access port. Each port uses a request/ready handshake. One transaction is in flight at a time, with a fixed, parameterised memory latency. The requester whose request is not ready must stall: IF holds pc and IF/ID, MEM freezes EX/MEM and earlier stages. The arbiter replaces the separate instruction and data memories in the core.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for instruction-fetch and data ports
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed data-first priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              owner_q;  // 1 = data port owns the transaction
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant;
  logic              grant_d;

  assign grant = (state_q == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;  // 1 = data port granted last

  assign grant_d = d_req && (!i_req || !last_owner_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= 1'b0;
    end else if (grant) begin
      last_owner_q <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: busy = 1'b0;
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      RESP: begin
        i_ready = !owner_q;
        d_ready = owner_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // The memory side only ever sees the latched copy, so requesters may glitch mid-access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (grant) begin
      cnt_q   <= CNT_INIT;
      owner_q <= grant_d;
      we_q    <= grant_d && d_we;
      addr_q  <= grant_d ? d_addr : i_addr;
      wdata_q <= grant_d ? d_wdata : '0;
    end else if (state_q == ACCESS) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else if (!we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_en"}, 32'(mem_en), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " i_ready"}, 32'(i_ready), 32'd0);
    check({tag, " d_ready"}, 32'(d_ready), 32'd0);
    check({tag, " i_rdata"}, i_rdata, 32'd0);
    check({tag, " d_rdata"}, d_rdata, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Called in the cycle whose closing edge grants the access; returns in the following IDLE cycle.
  task automatic do_access(input string tag, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd_exp);
    for (int c = 0; c < WAIT; c++) begin
      step();
      check({tag, " mem_en"}, 32'(mem_en), 32'd1);
      check({tag, " mem_we"}, 32'(mem_we), 32'(we));
      check({tag, " mem_addr"}, mem_addr, addr);
      if (we) check({tag, " mem_wdata"}, mem_wdata, wdata);
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " early ready"}, 32'({i_ready, d_ready}), 32'd0);
    end
    step();
    check({tag, " resp mem_en"}, 32'(mem_en), 32'd0);
    check({tag, " resp mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " i_ready"}, 32'(i_ready), 32'(!is_d));
    check({tag, " d_ready"}, 32'(d_ready), 32'(is_d));
    check({tag, " i_rdata"}, i_rdata, rd_exp);
    check({tag, " d_rdata"}, d_rdata, rd_exp);
    check({tag, " resp busy"}, 32'(busy), 32'd1);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
    step();
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle ready"}, 32'({i_ready, d_ready}), 32'd0);
    check({tag, " idle mem_en"}, 32'(mem_en), 32'd0);
  endtask

  initial begin
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check_all_zero("post-reset idle");

    // Instruction fetch
    i_req = 1'b1;
    i_addr = 32'h10;
    mem_rdata = 32'h0000_0013;
    do_access("fetch", 1'b0, 1'b0, 32'h10, 32'h0, 32'h13);

    // Store leaves read data unchanged
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h0BAD_0BAD;
    do_access("store", 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h13);
    check("store hold mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store hold mem_addr", mem_addr, 32'h40);

    // Simultaneous requests: data first, fetch granted on the following IDLE edge
    d_we = 1'b0;
    d_addr = 32'h44;
    i_addr = 32'h20;
    mem_rdata = 32'h55;
    i_req = 1'b1;
    d_req = 1'b1;
    do_access("contend d", 1'b1, 1'b0, 32'h44, 32'h0, 32'h55);
    mem_rdata = 32'h66;
    do_access("contend i", 1'b0, 1'b0, 32'h20, 32'h0, 32'h66);

    // Repeated contention
    i_req = 1'b1;
    d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      bit exp_d;
`ifdef MEM_ARB_RR_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      mem_rdata = 32'h100 + 32'(g);
      do_access($sformatf("rr%0d", g), exp_d, 1'b0, exp_d ? 32'h44 : 32'h20,
                32'h0, 32'h100 + 32'(g));
      i_req = 1'b1;
      d_req = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // Reset in the second ACCESS cycle of a load
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h48;
    mem_rdata = 32'h77;
    step();
    check("pre-abort mem_en", 32'(mem_en), 32'd1);
    step();
    check("pre-abort mem_en 2", 32'(mem_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    step();
    check_all_zero("abort hold");
    step();
    check("abort no d_ready", 32'(d_ready), 32'd0);
    reset_n = 1'b1;
    do_access("after reset", 1'b1, 1'b0, 32'h48, 32'h0, 32'h77);

    // Address change mid-access must not reach the memory
    d_req = 1'b1;
    d_addr = 32'h40;
    mem_rdata = 32'h99;
    step();
    check("addr change mem_addr 1", mem_addr, 32'h40);
    d_addr = 32'h80;
    step();
    check("addr change mem_addr 2", mem_addr, 32'h40);
    check("addr change mem_en 2", 32'(mem_en), 32'd1);
    step();
    check("addr change d_ready", 32'(d_ready), 32'd1);
    check("addr change d_rdata", d_rdata, 32'h99);
    d_req = 1'b0;
    step();
    check("addr change done", 32'({busy, d_ready}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
